// File: rtl/dmem_mmio_resp_if.sv
// ============================================================================
// dmem_mmio_resp_if : M-stage data-memory port plus console drain and timer IRQ
// Rev 1.0
// ============================================================================
`default_nettype none

interface dmem_mmio_resp_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        memwrite;
    logic [3:0]  amp;
    logic [31:0] rdata;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;
    logic        timer_irq;

    modport master (
        output addr, wdata, memwrite, amp, con_ready,
        input  rdata, con_valid, con_data, timer_irq
    );

    modport slave (
        input  addr, wdata, memwrite, amp, con_ready,
        output rdata, con_valid, con_data, timer_irq
    );
endinterface

`default_nettype wire

// File: rtl/dmem_mmio_resp.sv
// ============================================================================
// dmem_mmio_resp : word RAM + MMIO console FIFO + optional 64-bit machine timer
// Optional timer enabled by defining DMEM_TIMER_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module dmem_mmio_resp #(
    parameter int RAM_AW     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    dmem_mmio_resp_if.slave        bus
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [5:0] c_OFF_CON_DATA   = 6'h00;
    localparam logic [5:0] c_OFF_CON_STATUS = 6'h01;
`ifdef DMEM_TIMER_EN
    localparam logic [5:0] c_OFF_MTIME_LO   = 6'h02;
    localparam logic [5:0] c_OFF_MTIME_HI   = 6'h03;
    localparam logic [5:0] c_OFF_MTCMP_LO   = 6'h04;
    localparam logic [5:0] c_OFF_MTCMP_HI   = 6'h05;
`endif

    // ------------------------------------------------------------------
    // Decode and lane steering
    // ------------------------------------------------------------------
    logic              w_we;
    logic              w_is_mmio;
    logic              w_ram_we;
    logic              w_mmio_we;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [5:0]        w_off;
    logic [31:0]       w_lane_data;
    logic [31:0]       w_lane_mask;
    logic              w_unused_addr;

    assign w_we      = bus.memwrite & (|bus.amp);
    assign w_is_mmio = bus.addr[31];
    assign w_ram_we  = w_we & ~w_is_mmio;
    assign w_mmio_we = w_we & w_is_mmio;
    assign w_ram_idx = bus.addr[RAM_AW+1:2];
    assign w_off     = bus.addr[7:2];
    assign w_unused_addr = ^bus.addr;

    // The core hands over the raw rs2 value; replicate it so any enabled lane sees it
    always_comb begin
        case (bus.amp)
            4'b1111:          w_lane_data = bus.wdata;
            4'b0011, 4'b1100: w_lane_data = {2{bus.wdata[15:0]}};
            default:          w_lane_data = {4{bus.wdata[7:0]}};
        endcase
    end

    assign w_lane_mask = {{8{bus.amp[3]}}, {8{bus.amp[2]}}, {8{bus.amp[1]}}, {8{bus.amp[0]}}};

    // ------------------------------------------------------------------
    // Word RAM (no reset)
    // ------------------------------------------------------------------
    logic [31:0] r_ram [2**RAM_AW];

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.amp[i]) begin
                    r_ram[w_ram_idx][8*i +: 8] <= w_lane_data[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Console FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_ovf;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push_req;
    logic               w_push;
    logic               w_status_we;
    logic [31:0]        w_status;

    assign w_full      = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_pop       = ~w_empty & bus.con_ready;
    assign w_push_req  = w_mmio_we & (w_off == c_OFF_CON_DATA);
    // A simultaneous pop frees a slot, so a full FIFO still accepts the push
    assign w_push      = w_push_req & (~w_full | w_pop);
    assign w_status_we = w_mmio_we & (w_off == c_OFF_CON_STATUS);
    assign w_status    = {22'b0, r_ovf, 8'(r_count), w_empty};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= bus.wdata[7:0];
                r_wptr         <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_push_req && !w_push) begin
                r_ovf <= 1'b1;
            end else if (w_status_we) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.con_valid = ~w_empty;
    assign bus.con_data  = r_fifo[r_rptr];

    // ------------------------------------------------------------------
    // Machine timer
    // ------------------------------------------------------------------
`ifdef DMEM_TIMER_EN
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_irq;

    function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mtime    <= '0;
            r_mtimecmp <= '1;
            r_irq      <= 1'b0;
        end else begin
            r_irq <= (r_mtime >= r_mtimecmp);
            if (w_mmio_we && (w_off == c_OFF_MTIME_LO)) begin
                r_mtime[31:0] <= f_merge(r_mtime[31:0], w_lane_data, w_lane_mask);
            end else if (w_mmio_we && (w_off == c_OFF_MTIME_HI)) begin
                r_mtime[63:32] <= f_merge(r_mtime[63:32], w_lane_data, w_lane_mask);
            end else begin
                r_mtime <= r_mtime + 64'd1;
            end
            if (w_mmio_we && (w_off == c_OFF_MTCMP_LO)) begin
                r_mtimecmp[31:0] <= f_merge(r_mtimecmp[31:0], w_lane_data, w_lane_mask);
            end
            if (w_mmio_we && (w_off == c_OFF_MTCMP_HI)) begin
                r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], w_lane_data, w_lane_mask);
            end
        end
    end

    assign bus.timer_irq = r_irq;
`else
    assign bus.timer_irq = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read mux: combinational, always the pre-write state
    // ------------------------------------------------------------------
    always_comb begin
        bus.rdata = '0;
        if (!w_is_mmio) begin
            bus.rdata = r_ram[w_ram_idx];
        end else begin
            case (w_off)
                c_OFF_CON_STATUS: bus.rdata = w_status;
`ifdef DMEM_TIMER_EN
                c_OFF_MTIME_LO:   bus.rdata = r_mtime[31:0];
                c_OFF_MTIME_HI:   bus.rdata = r_mtime[63:32];
                c_OFF_MTCMP_LO:   bus.rdata = r_mtimecmp[31:0];
                c_OFF_MTCMP_HI:   bus.rdata = r_mtimecmp[63:32];
`endif
                default:          bus.rdata = '0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_mmio_resp.sv
// ============================================================================
// tb_dmem_mmio_resp : scoreboard bench with a queue-based reference model
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_mmio_resp;

    localparam int RAM_AW     = 10;
    localparam int FIFO_DEPTH = 4;

    localparam logic [31:0] MMIO      = 32'h8000_0000;
    localparam logic [31:0] CON_DATA  = MMIO | 32'h00;
    localparam logic [31:0] CON_STAT  = MMIO | 32'h04;
    localparam logic [31:0] MT_LO     = MMIO | 32'h08;
    localparam logic [31:0] MT_HI     = MMIO | 32'h0C;
    localparam logic [31:0] CMP_LO    = MMIO | 32'h10;
    localparam logic [31:0] CMP_HI    = MMIO | 32'h14;

    logic clk = 1'b0;
    logic reset;

    dmem_mmio_resp_if bus();

    dmem_mmio_resp #(.RAM_AW(RAM_AW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          chk_rd;
        logic [31:0] rd;
        bit          valid;
        logic [7:0]  head;
        bit          irq;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] con_q[$];

    // Reference model state (value held during the current cycle)
    logic [31:0] m_ram [int];
    logic [7:0]  m_fifo[$];
    bit          m_ovf;
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    bit          m_irq;

    // Inputs driven this cycle, applied at the next rising edge
    bit          p_mw;
    logic [3:0]  p_amp;
    logic [31:0] p_addr;
    logic [31:0] p_wd;
    bit          p_cr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Store result on a word: each enabled byte takes the byte the access size implies
    function automatic logic [31:0] store_merge(input logic [3:0] amp, input logic [31:0] wd,
                                                input logic [31:0] old);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (amp[i]) begin
                if (amp == 4'b1111)                       r[8*i +: 8] = wd[8*i +: 8];
                else if (amp == 4'b0011 || amp == 4'b1100) r[8*i +: 8] = wd[8*(i%2) +: 8];
                else                                       r[8*i +: 8] = wd[7:0];
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_ovf   = 0;
        m_mtime = 64'd0;
        m_cmp   = '1;
        m_irq   = 0;
        p_mw = 0; p_amp = 4'h0; p_addr = 32'h0; p_wd = 32'h0; p_cr = 0;
    endtask

    task automatic model_read(input logic [31:0] a, output bit ok, output logic [31:0] v);
        int idx;
        ok = 1;
        v  = 32'h0;
        if (!a[31]) begin
            idx = int'(a[11:2]);
            if (m_ram.exists(idx)) v = m_ram[idx];
            else ok = 0;
        end else begin
            case (a[7:0])
                8'h04: v = (32'(m_ovf) << 9) | (32'(m_fifo.size()) << 1) | ((m_fifo.size() == 0) ? 32'd1 : 32'd0);
`ifdef DMEM_TIMER_EN
                8'h08: v = m_mtime[31:0];
                8'h0C: v = m_mtime[63:32];
                8'h10: v = m_cmp[31:0];
                8'h14: v = m_cmp[63:32];
`endif
                default: v = 32'h0;
            endcase
        end
    endtask

    task automatic model_step();
        bit          we;
        bit          irq_next;
        logic [63:0] mt_next;
        int          idx;
        we       = p_mw && (p_amp != 4'h0);
        irq_next = (m_mtime >= m_cmp);
        mt_next  = m_mtime + 64'd1;
        if (p_cr && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (we && !p_addr[31]) begin
            idx = int'(p_addr[11:2]);
            if (m_ram.exists(idx))   m_ram[idx] = store_merge(p_amp, p_wd, m_ram[idx]);
            else if (p_amp == 4'hF)  m_ram[idx] = p_wd;
        end
        if (we && p_addr[31]) begin
            case (p_addr[7:0])
                8'h00: if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(p_wd[7:0]);
                       else m_ovf = 1;
                8'h04: m_ovf = 0;
`ifdef DMEM_TIMER_EN
                8'h08: mt_next = {m_mtime[63:32], store_merge(p_amp, p_wd, m_mtime[31:0])};
                8'h0C: mt_next = {store_merge(p_amp, p_wd, m_mtime[63:32]), m_mtime[31:0]};
                8'h10: m_cmp[31:0]  = store_merge(p_amp, p_wd, m_cmp[31:0]);
                8'h14: m_cmp[63:32] = store_merge(p_amp, p_wd, m_cmp[63:32]);
`endif
                default: ;
            endcase
        end
`ifdef DMEM_TIMER_EN
        m_mtime = mt_next;
        m_irq   = irq_next;
`else
        m_irq   = 0;
`endif
    endtask

    // One access cycle: advance model over the edge, drive, enqueue expectations
    task automatic drive(input bit mw, input logic [3:0] amp, input logic [31:0] a,
                         input logic [31:0] wd, input bit cr);
        exp_t        e;
        bit          ok;
        logic [31:0] v;
        @(posedge clk);
        model_step();
        #1;
        bus.memwrite  = mw;
        bus.amp       = amp;
        bus.addr      = a;
        bus.wdata     = wd;
        bus.con_ready = cr;
        p_mw = mw; p_amp = amp; p_addr = a; p_wd = wd; p_cr = cr;
        model_read(a, ok, v);
        e.chk_rd = ok;
        e.rd     = v;
        e.valid  = (m_fifo.size() > 0);
        e.head   = (m_fifo.size() > 0) ? m_fifo[0] : 8'h00;
        e.irq    = m_irq;
        if (cr && m_fifo.size() > 0) con_q.push_back(m_fifo[0]);
        exp_q.push_back(e);
    endtask

    task automatic rd(input logic [31:0] a, input bit cr);
        drive(0, 4'h0, a, 32'h0, cr);
    endtask

    // Monitor: compares whatever the DUT presents in each checked cycle
    always @(negedge clk) begin
        exp_t e;
        if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk_rd) chk("rdata", bus.rdata, e.rd);
            chk("con_valid", 32'(bus.con_valid), 32'(e.valid));
            if (e.valid) chk("con_data_head", 32'(bus.con_data), 32'(e.head));
            chk("timer_irq", 32'(bus.timer_irq), 32'(e.irq));
            if (bus.con_valid && bus.con_ready) begin
                if (con_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL con_pop: got unexpected byte %h expected none", bus.con_data);
                end else begin
                    chk("con_pop", 32'(bus.con_data), 32'(con_q.pop_front()));
                end
            end
        end
    end

    task automatic reset_checks();
        #1;
        chk("rst_con_valid", 32'(bus.con_valid), 32'h0);
        chk("rst_con_data",  32'(bus.con_data),  32'h0);
        chk("rst_timer_irq", 32'(bus.timer_irq), 32'h0);
        bus.memwrite = 0; bus.amp = 4'h0; bus.con_ready = 0; bus.addr = CON_STAT;
        #1;
        chk("rst_status", bus.rdata, 32'h1);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  amps [8];
        logic [7:0]  offs [8];
        amps = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h40};

        reset = 1;
        bus.memwrite = 0; bus.amp = 4'h0; bus.addr = 32'h0; bus.wdata = 32'h0; bus.con_ready = 0;
        #3;
        reset_checks();
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        reset = 0;

        // Word, byte and half stores with read-back
        drive(1, 4'hF, 32'h10, 32'h1122_3344, 0);
        rd(32'h10, 0);
        drive(1, 4'b0100, 32'h10, 32'h0000_00AB, 0);
        rd(32'h10, 0);
        drive(1, 4'hF, 32'h20, 32'h0, 0);
        drive(1, 4'b1100, 32'h20, 32'h0000_BEEF, 0);
        rd(32'h20, 0);
        drive(1, 4'h0, 32'h20, 32'hFFFF_FFFF, 0);
        rd(32'h20, 0);
        rd(32'h0001_2020, 0);
        for (int i = 0; i < 16; i++) drive(1, 4'hF, 32'(i * 4), $urandom, 0);

        // Overflow: five pushes into a four-deep FIFO with the sink stalled
        for (int i = 0; i < 5; i++) drive(1, 4'h1, CON_DATA, 32'h41 + 32'(i), 0);
        rd(CON_STAT, 0);
        rd(CON_DATA, 0);
        repeat (2) rd(CON_STAT, 0);
        repeat (6) rd(CON_STAT, 1);

        // Push coinciding with pop while full
        drive(1, 4'hF, CON_STAT, 32'h0, 0);
        for (int i = 0; i < 4; i++) drive(1, 4'h2, CON_DATA, 32'h31 + 32'(i), 0);
        drive(1, 4'h8, CON_DATA, 32'h58, 1);
        rd(CON_STAT, 0);
        repeat (5) rd(CON_STAT, 1);

        // Timer compare and carry
        drive(1, 4'hF, CMP_HI, 32'h0, 0);
        drive(1, 4'hF, CMP_LO, 32'd50, 0);
        drive(1, 4'hF, MT_LO, 32'd40, 0);
        repeat (14) rd(MT_LO, 0);
        drive(1, 4'hF, MT_LO, 32'hFFFF_FFFF, 0);
        repeat (3) rd(MT_HI, 0);
        drive(1, 4'h1, CMP_HI, 32'hFF, 0);
        repeat (3) rd(CMP_HI, 0);

        // Randomized mix of RAM and MMIO traffic
        for (int n = 0; n < 600; n++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                a[31]   = 1'b0;
                a[11:2] = 10'($urandom_range(0, 15));
            end else begin
                a[31]  = 1'b1;
                a[7:0] = offs[$urandom_range(0, 7)];
            end
            a[1:0] = 2'b00;
            drive(bit'($urandom_range(0, 1)), amps[$urandom_range(0, 7)], a, $urandom,
                  bit'($urandom_range(0, 2) == 0));
        end

        // Asynchronous reset in the middle of a drain
        repeat (6) rd(CON_STAT, 1);
        for (int i = 0; i < 4; i++) drive(1, 4'h1, CON_DATA, 32'h61 + 32'(i), 0);
        rd(CON_STAT, 1);
        #6;
        reset = 1;
        reset_checks();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        rd(CON_STAT, 0);
        drive(1, 4'h1, CON_DATA, 32'h7A, 0);
        rd(CON_STAT, 0);

        for (int i = 0; i < 20 && m_fifo.size() > 0; i++) rd(CON_STAT, 1);
        repeat (2) rd(CON_STAT, 0);
        #6;
        chk("con_q_drained", 32'(con_q.size()), 32'h0);
        chk("exp_q_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
